// File: rtl/i2c_av_pkg.sv
// Shared types and constants for the audio/video configuration I2C target.
//   i2c_target_state_t : protocol state of the target FSM
//   WRITE_ADDR_BYTE    : address byte on the wire for a write to the default device
//   i2c_payload_t      : decoded {register address, register value} pair
//   decode_payload()   : splits the two data bytes into address and value
package i2c_av_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_BYTE1,
    ST_BYTE1_ACK,
    ST_BYTE2,
    ST_BYTE2_ACK,
    ST_IGNORE
  } i2c_target_state_t;

  localparam logic [7:0] WRITE_ADDR_BYTE = 8'h34;
  localparam int         REG_ADDR_W      = 7;
  localparam int         REG_DATA_W      = 9;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] reg_addr;
    logic [REG_DATA_W-1:0] reg_data;
  } i2c_payload_t;

  // Byte1 carries the register address in its top 7 bits and the value MSB in
  // bit 0; byte2 carries the low 8 bits of the value.
  function automatic i2c_payload_t decode_payload(input logic [7:0] byte1,
                                                  input logic [7:0] byte2);
    i2c_payload_t p;
    p.reg_addr = byte1[7:1];
    p.reg_data = {byte1[0], byte2};
    return p;
  endfunction

endpackage

// File: rtl/i2c_bus_sync_edge.sv
// Synchronizer and bus-condition detector for SCL/SDA.
//   clk, reset            : system clock, async active-high reset
//   scl_async, sda_async  : raw bus lines
//   scl_rise, scl_fall    : one-cycle edge flags of synchronized SCL
//   sda_level             : synchronized SDA
//   start_cond, stop_cond : SDA falling / rising while synchronized SCL is high
// SYNC_STAGES must be 2 or more.
module i2c_bus_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_async,
  input  logic sda_async,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_level,
  output logic start_cond,
  output logic stop_cond
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_hist;
  logic                   sda_hist;
  logic                   scl_s;

  // Flops reset to 1 so leaving reset on an idle bus produces no edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_hist <= 1'b1;
      sda_hist <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the previous
      // stage's old value, which is what builds a real shift chain.
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_async};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_async};
      scl_hist <= scl_sync[SYNC_STAGES-1];
      sda_hist <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s      = scl_sync[SYNC_STAGES-1];
  assign sda_level  = sda_sync[SYNC_STAGES-1];
  assign scl_rise   = scl_s & ~scl_hist;
  assign scl_fall   = ~scl_s & scl_hist;
  assign start_cond = scl_s & ~sda_level & sda_hist;
  assign stop_cond  = scl_s & sda_level & ~sda_hist;

endmodule

// File: rtl/i2c_av_config_target.sv
// I2C write-only target for the A/V configuration bus.
//   clk, reset          : system clock (>= 8x SCL), async active-high reset
//   i2c_sclk            : bus SCL
//   i2c_sdat_in         : bus SDA from the pad
//   i2c_sdat_oe         : 1 pulls SDA low (ACK); never drives high
//   reg_write           : one-cycle strobe when a 3-byte write completes
//   reg_addr, reg_data  : decoded payload, held until the next write
//   addr_match          : one-cycle pulse on a matching write address byte
//   busy                : high between START and STOP
//   write_count         : accepted writes, saturating at 8'hFF
module i2c_av_config_target
  import i2c_av_pkg::*;
#(
  parameter logic [6:0] DEVICE_ADDR = WRITE_ADDR_BYTE[7:1],
  parameter int         SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i2c_sclk,
  input  logic                  i2c_sdat_in,
  output logic                  i2c_sdat_oe,
  output logic                  reg_write,
  output logic [REG_ADDR_W-1:0] reg_addr,
  output logic [REG_DATA_W-1:0] reg_data,
  output logic                  addr_match,
  output logic                  busy,
  output logic [7:0]            write_count
);

  logic scl_rise, scl_fall, sda_level, start_cond, stop_cond;

  i2c_bus_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .reset      (reset),
    .scl_async  (i2c_sclk),
    .sda_async  (i2c_sdat_in),
    .scl_rise   (scl_rise),
    .scl_fall   (scl_fall),
    .sda_level  (sda_level),
    .start_cond (start_cond),
    .stop_cond  (stop_cond)
  );

  i2c_target_state_t state_q, state_d;
  logic              oe_q, oe_d;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift_q, byte1_q;
  logic [7:0]        shift_in;
  logic              sample, cnt_clr, b1_latch, match_d, write_d;
  i2c_payload_t      payload;

  assign shift_in = {shift_q[6:0], sda_level};
  assign payload  = decode_payload(byte1_q, shift_q);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d  = state_q;
    oe_d     = oe_q;
    sample   = 1'b0;
    cnt_clr  = 1'b0;
    b1_latch = 1'b0;
    match_d  = 1'b0;
    write_d  = 1'b0;
    // Bus conditions win over any SCL edge seen in the same cycle.
    if (start_cond) begin
      state_d = ST_ADDR;
      oe_d    = 1'b0;
      cnt_clr = 1'b1;
    end else if (stop_cond) begin
      state_d = ST_IDLE;
      oe_d    = 1'b0;
      cnt_clr = 1'b1;
    end else begin
      unique case (state_q)
        ST_ADDR, ST_BYTE1, ST_BYTE2: begin
          if (scl_rise) begin
            sample = 1'b1;
            if (bit_cnt == 3'd7) begin
              if (state_q == ST_ADDR) begin
                if (shift_in == {DEVICE_ADDR, 1'b0}) begin
                  match_d = 1'b1;
                  state_d = ST_ADDR_ACK;
                end else begin
                  state_d = ST_IGNORE;
                end
              end else if (state_q == ST_BYTE1) begin
                b1_latch = 1'b1;
                state_d  = ST_BYTE1_ACK;
              end else begin
                state_d = ST_BYTE2_ACK;
              end
            end
          end
        end
        // First SCL fall in an ACK state pulls SDA low; the second ends the
        // 9th clock, releases SDA and moves on.
        ST_ADDR_ACK, ST_BYTE1_ACK, ST_BYTE2_ACK: begin
          if (scl_fall) begin
            if (!oe_q) begin
              oe_d    = 1'b1;
              write_d = (state_q == ST_BYTE2_ACK);
            end else begin
              oe_d    = 1'b0;
              cnt_clr = 1'b1;
              state_d = (state_q == ST_ADDR_ACK)  ? ST_BYTE1 :
                        (state_q == ST_BYTE1_ACK) ? ST_BYTE2 : ST_IGNORE;
            end
          end
        end
        default: ;  // IDLE and IGNORE leave only on START/STOP
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      oe_q        <= 1'b0;
      bit_cnt     <= '0;
      shift_q     <= '0;
      byte1_q     <= '0;
      reg_write   <= 1'b0;
      addr_match  <= 1'b0;
      reg_addr    <= '0;
      reg_data    <= '0;
      write_count <= '0;
    end else begin
      state_q    <= state_d;
      oe_q       <= oe_d;
      reg_write  <= write_d;
      addr_match <= match_d;
      if (cnt_clr)     bit_cnt <= '0;
      else if (sample) bit_cnt <= bit_cnt + 3'd1;
      if (sample)   shift_q <= shift_in;
      if (b1_latch) byte1_q <= shift_in;
      if (write_d) begin
        reg_addr <= payload.reg_addr;
        reg_data <= payload.reg_data;
        if (write_count != 8'hFF) write_count <= write_count + 8'd1;
      end
    end
  end

  assign i2c_sdat_oe = oe_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_i2c_av_config_target.sv
module tb_i2c_av_config_target;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl_drv;
  logic       sda_drv;
  logic       i2c_sdat_in;
  logic       i2c_sdat_oe;
  logic       reg_write;
  logic [6:0] reg_addr;
  logic [8:0] reg_data;
  logic       addr_match;
  logic       busy;
  logic [7:0] write_count;

  // Open-drain bus: SDA is low if either side pulls it low.
  assign i2c_sdat_in = sda_drv & ~i2c_sdat_oe;

  i2c_av_config_target dut (
    .clk         (clk),
    .reset       (reset),
    .i2c_sclk    (scl_drv),
    .i2c_sdat_in (i2c_sdat_in),
    .i2c_sdat_oe (i2c_sdat_oe),
    .reg_write   (reg_write),
    .reg_addr    (reg_addr),
    .reg_data    (reg_data),
    .addr_match  (addr_match),
    .busy        (busy),
    .write_count (write_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_count = 0;
  bit held = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Strobe monitor, sampled on the falling clock edge.
  int         wr_pulses = 0;
  int         match_pulses = 0;
  logic [6:0] mon_addr = '0;
  logic [8:0] mon_data = '0;
  always @(negedge clk) begin
    if (reg_write) begin
      wr_pulses++;
      mon_addr = reg_addr;
      mon_data = reg_data;
    end
    if (addr_match) match_pulses++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Bus master primitives; one SCL period is 8 clk.
  task automatic bus_start();
    if (held) begin
      sda_drv = 1'b1; wait_clk(2);
      scl_drv = 1'b1; wait_clk(2);
    end
    sda_drv = 1'b0; wait_clk(2);
    scl_drv = 1'b0; wait_clk(2);
    held = 1'b1;
  endtask

  task automatic bus_stop();
    sda_drv = 1'b0; wait_clk(2);
    scl_drv = 1'b1; wait_clk(2);
    sda_drv = 1'b1; wait_clk(4);
    held = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    sda_drv = b;    wait_clk(2);
    scl_drv = 1'b1; wait_clk(4);
    scl_drv = 1'b0; wait_clk(2);
  endtask

  task automatic ack_bit(output logic acked);
    sda_drv = 1'b1; wait_clk(2);
    scl_drv = 1'b1; wait_clk(2);
    acked = i2c_sdat_oe;
    wait_clk(2);
    scl_drv = 1'b0; wait_clk(2);
  endtask

  task automatic send_byte(input logic [7:0] v, output logic acked);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
    ack_bit(acked);
  endtask

  task automatic run_txn(input logic [31:0] bytes, input int n, input bit do_stop,
                         output logic [3:0] acks);
    logic a;
    acks = '0;
    bus_start();
    for (int i = 0; i < n; i++) begin
      send_byte(bytes[31-8*i -: 8], a);
      acks[i] = a;
    end
    if (do_stop) bus_stop();
  endtask

  // Reference: only a write to 0x34 is acknowledged, for at most three bytes;
  // three complete bytes make one register write.
  function automatic void model(input logic [31:0] bytes, input int n,
                                output logic [3:0] acks, output bit wr,
                                output logic [6:0] a, output logic [8:0] d);
    int b0, b1, b2;
    bit addressed;
    b0 = int'(bytes[31:24]);
    b1 = int'(bytes[23:16]);
    b2 = int'(bytes[15:8]);
    addressed = (b0 == 'h1A * 2);
    acks = '0;
    for (int i = 0; i < n && i < 3; i++) acks[i] = addressed;
    wr = addressed && (n >= 3);
    a  = 7'(b1 / 2);
    d  = 9'((b1 % 2) * 256 + b2);
  endfunction

  task automatic apply(input string nm, input logic [31:0] bytes, input int n,
                       input bit do_stop, input logic [3:0] e_acks, input bit e_wr,
                       input logic [6:0] e_a, input logic [8:0] e_d);
    int w0, m0;
    logic [3:0] acks;
    w0 = wr_pulses;
    m0 = match_pulses;
    run_txn(bytes, n, do_stop, acks);
    wait_clk(2);
    check({nm, " acks"}, acks, e_acks);
    check({nm, " reg_write pulses"}, wr_pulses - w0, e_wr);
    check({nm, " addr_match pulses"}, match_pulses - m0, e_acks[0]);
    if (e_wr) begin
      check({nm, " strobe reg_addr"}, mon_addr, e_a);
      check({nm, " strobe reg_data"}, mon_data, e_d);
      check({nm, " held reg_addr"}, reg_addr, e_a);
      if (exp_count < 255) exp_count++;
    end
    check({nm, " write_count"}, write_count, exp_count);
    check({nm, " busy"}, busy, !do_stop);
  endtask

  typedef struct {
    logic [31:0] bytes;
    int          n;
    bit          do_stop;
    logic [3:0]  exp_acks;
    bit          exp_wr;
    logic [6:0]  exp_a;
    logic [8:0]  exp_d;
  } vec_t;

  vec_t        vecs[7];
  logic [31:0] rb;
  int          rn;
  bit          rs;
  logic [3:0]  ea;
  bit          ew;
  logic [6:0]  eaddr;
  logic [8:0]  edata;
  logic        a_tmp;

  initial begin
    vecs[0] = '{32'h340E_0100, 3, 1'b1, 4'b0111, 1'b1, 7'h07, 9'h001};
    vecs[1] = '{32'h40AA_5500, 3, 1'b1, 4'b0000, 1'b0, 7'h00, 9'h000};
    vecs[2] = '{32'h3512_0000, 2, 1'b0, 4'b0000, 1'b0, 7'h00, 9'h000};  // read: ignored, bus stays busy
    vecs[3] = '{32'h3408_0000, 2, 1'b0, 4'b0011, 1'b0, 7'h00, 9'h000};  // aborted by repeated START
    vecs[4] = '{32'h3412_F800, 3, 1'b1, 4'b0111, 1'b1, 7'h09, 9'h0F8};
    vecs[5] = '{32'h340C_0000, 2, 1'b1, 4'b0011, 1'b0, 7'h00, 9'h000};  // STOP after byte1
    vecs[6] = '{32'h340C_00AA, 4, 1'b1, 4'b0111, 1'b1, 7'h06, 9'h000};  // 4th byte NACKed

    reset = 1'b1; scl_drv = 1'b1; sda_drv = 1'b1;
    wait_clk(3);
    check("reset sdat_oe", i2c_sdat_oe, 0);
    check("reset reg_write", reg_write, 0);
    check("reset addr_match", addr_match, 0);
    check("reset busy", busy, 0);
    check("reset write_count", write_count, 0);
    check("reset reg_addr", reg_addr, 0);
    check("reset reg_data", reg_data, 0);
    reset = 1'b0;
    wait_clk(4);

    for (int i = 0; i < 7; i++)
      apply($sformatf("vec%0d", i), vecs[i].bytes, vecs[i].n, vecs[i].do_stop,
            vecs[i].exp_acks, vecs[i].exp_wr, vecs[i].exp_a, vecs[i].exp_d);

    for (int k = 0; k < 24; k++) begin
      rb = $urandom;
      if ($urandom_range(0, 1) == 1) rb[31:24] = 8'h34;
      rn = $urandom_range(1, 4);
      rs = ($urandom_range(0, 3) != 0);
      model(rb, rn, ea, ew, eaddr, edata);
      apply($sformatf("rand%0d", k), rb, rn, rs, ea, ew, eaddr, edata);
    end
    if (held) bus_stop();

    // Reset while the target is pulling SDA low for the byte1 ACK.
    bus_start();
    send_byte(8'h34, a_tmp);
    for (int i = 7; i >= 0; i--) send_bit(rb[i] & 1'b0 | (8'h0E >> i) & 1'b1);
    sda_drv = 1'b1; wait_clk(2);
    scl_drv = 1'b1; wait_clk(2);
    check("byte1 ACK before reset", i2c_sdat_oe, 1);
    reset = 1'b1;
    #1;
    check("sdat_oe released by reset", i2c_sdat_oe, 0);
    check("write_count cleared by reset", write_count, 0);
    check("busy cleared by reset", busy, 0);
    wait_clk(3);
    reset = 1'b0;
    held = 1'b0;
    exp_count = 0;
    wait_clk(4);
    apply("after reset", 32'h3422_3300, 3, 1'b1, 4'b0111, 1'b1, 7'h11, 9'h033);

    // 299 more writes back to back (repeated STARTs) drive the counter into saturation.
    for (int k = 0; k < 299; k++) begin
      rb = {8'h34, 8'($urandom), 8'($urandom), 8'h00};
      model(rb, 3, ea, ew, eaddr, edata);
      apply($sformatf("sat%0d", k), rb, 3, 1'b0, ea, ew, eaddr, edata);
    end
    bus_stop();
    wait_clk(2);
    check("saturated write_count", write_count, 8'hFF);
    check("busy after final stop", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
